// File: rtl/darwin_link_pkg.sv
// Shared types for the Darwin3 west-port link, used by both the RX and TX stages.
// Holds the link width, the handshake FSM states and the buffered word layout.
package darwin_link_pkg;

  localparam int LINK_DATA_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } link_state_t;

  typedef struct packed {
    logic                   last;
    logic [LINK_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/darwin_rx_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO with occupancy level.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop occurs in the same cycle.
module darwin_rx_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign rd_en   = pop && !empty;
  // When full, the write slot is the one being read out this cycle.
  assign wr_en   = push && (!full || rd_en);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/darwin_rx.sv
// Purpose: 4-phase REQ/ACK receiver feeding an AXI4-Stream master through a FWFT FIFO.
// Latency: REQ rise -> ACK on 3rd clk edge, word on M_AXIS one cycle later; optional DARWIN_RX_WORD_CNT_EN.
// Backpressure: a full FIFO withholds ACK so the chip stalls until a beat is popped.
module darwin_rx
  import darwin_link_pkg::*;
#(
  parameter int DATA_W     = LINK_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_WORDS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX_REQ,
  input  logic [DATA_W-1:0]           RX_DATA,
  output logic                        RX_ACK,
  output logic [DATA_W-1:0]           M_AXIS_TDATA,
  output logic                        M_AXIS_TVALID,
  output logic [DATA_W/8-1:0]         M_AXIS_TKEEP,
  output logic                        M_AXIS_TLAST,
  input  logic                        M_AXIS_TREADY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic [31:0]                 RX_WORD_CNT
);

  localparam int BEAT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = (PKT_WORDS > 0) ? BEAT_W'(PKT_WORDS - 1) : '0;

  logic              req_m;
  logic              req_s;
  link_state_t       state;
  logic [BEAT_W-1:0] beat;
  logic              last_beat;
  logic              push_vld;
  fifo_entry_t       push_dat;
  fifo_entry_t       pop_dat;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= RX_REQ;
      req_s <= req_m;
    end
  end

  assign last_beat = (PKT_WORDS != 0) && (beat == BEAT_MAX);

  // The accepted word is staged one cycle before entering the FIFO; RX_DATA is
  // held by the chip until ACK, so sampling it on acceptance is safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      RX_ACK   <= 1'b0;
      push_vld <= 1'b0;
      push_dat <= '0;
      beat     <= '0;
    end else begin
      push_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s && !fifo_full) begin
            push_vld      <= 1'b1;
            push_dat.last <= last_beat;
            push_dat.data <= RX_DATA;
            RX_ACK        <= 1'b1;
            state         <= ACK_HI;
            beat          <= (PKT_WORDS == 0 || last_beat) ? '0 : beat + 1'b1;
          end
        end
        ACK_HI: begin
          if (!req_s) begin
            RX_ACK <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  darwin_rx_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .level    (FIFO_LEVEL),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign M_AXIS_TVALID = !fifo_empty;
  assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
  assign M_AXIS_TDATA  = pop_dat.data;
  assign M_AXIS_TLAST  = pop_dat.last;
  assign M_AXIS_TKEEP  = '1;

`ifdef DARWIN_RX_WORD_CNT_EN
  logic [31:0] word_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (push_vld && (word_cnt != 32'hFFFF_FFFF)) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

  assign RX_WORD_CNT = word_cnt;
`else
  assign RX_WORD_CNT = 32'd0;
`endif

endmodule
